// File: rtl/alien_swarm.sv
// ============================================================================
//  Module   : alien_swarm
//  Brief    : 4x8 alien grid that marches, drops at borders, takes bullet hits
//             and tracks level progression. Optional macro ALIEN_SPEEDUP_EN
//             halves the step period once eight or fewer aliens remain.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alien_swarm #(
    parameter logic [9:0] step_x_p          = 10'd4,
    parameter logic [9:0] drop_p            = 10'd16,
    parameter logic [5:0] frames_per_step_p = 6'd8,
    parameter logic [9:0] land_line_p       = 10'd384
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        frame_i,
    input  logic        freeze_i,
    input  logic        resume_i,
    input  logic        bullet_i,
    input  logic [9:0]  bullet_left_i,
    input  logic [9:0]  bullet_right_i,
    input  logic [9:0]  bullet_top_i,
    input  logic [9:0]  bullet_bot_i,
    output logic        hit_enemy_o,
    output logic [31:0] alive_mask_o,
    output logic [9:0]  swarm_left_o,
    output logic [9:0]  swarm_top_o,
    output logic [2:0]  level_o,
    output logic        add_life_o,
    output logic        cleared_o,
    output logic        landed_o
);

    localparam logic [1:0] ST_MARCH   = 2'd0;
    localparam logic [1:0] ST_DROP    = 2'd1;
    localparam logic [1:0] ST_CLEARED = 2'd2;
    localparam logic [1:0] ST_LANDED  = 2'd3;

    localparam logic [9:0] LEFT_RST = 10'd168;
    localparam logic [9:0] TOP_RST  = 10'd48;

    logic [1:0]  state_q, state_d;
    logic        dir_q, dir_d;
    logic [9:0]  swarm_left_q, swarm_left_d;
    logic [9:0]  swarm_top_q, swarm_top_d;
    logic [31:0] mask_q, mask_d;
    logic [2:0]  level_q, level_d;
    logic [5:0]  frame_cnt_q, frame_cnt_d;
    logic        hit_q, hit_d;
    logic        add_life_q, add_life_d;

    logic [31:0] w_overlap;
    logic [31:0] w_hit_vec;
    logic [31:0] w_kill;
    logic [31:0] w_mask_kill;
    logic        w_test_en;
    logic        w_tick;
    logic [5:0]  w_period;
    logic        w_any_live;
    logic [9:0]  w_low_bot;
    logic        w_landed;

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 8; c++) begin : g_col
            logic [9:0] w_l;
            logic [9:0] w_t;
            assign w_l = swarm_left_q + 10'(40 * c);
            assign w_t = swarm_top_q + 10'(32 * r);
            assign w_overlap[r*8+c] = (bullet_left_i < w_l + 10'd24) && (bullet_right_i > w_l)
                                   && (bullet_top_i < w_t + 10'd16) && (bullet_bot_i > w_t);
        end
    end

    // Suppressing while the kill pulse is high stops a lingering bullet from killing twice.
    assign w_test_en   = bullet_i && !hit_q && (state_q == ST_MARCH || state_q == ST_DROP);
    assign w_hit_vec   = w_test_en ? (w_overlap & mask_q) : 32'd0;
    assign w_kill      = w_hit_vec & (~w_hit_vec + 32'd1);
    assign w_mask_kill = mask_q & ~w_kill;

`ifdef ALIEN_SPEEDUP_EN
    localparam logic [5:0] HALF_PERIOD = ((frames_per_step_p >> 1) == 6'd0) ? 6'd1
                                                                           : (frames_per_step_p >> 1);
    logic [5:0] w_pop;
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < 32; i++) begin
            w_pop = w_pop + 6'(mask_q[i]);
        end
    end
    assign w_period = (w_pop <= 6'd8) ? HALF_PERIOD : frames_per_step_p;
`else
    assign w_period = frames_per_step_p;
`endif

    assign w_tick = frame_i && !freeze_i && (frame_cnt_q >= w_period - 6'd1);

    // Higher rows overwrite lower ones, leaving the bottom edge of the lowest live row.
    always_comb begin
        w_any_live = 1'b0;
        w_low_bot  = '0;
        for (int r = 0; r < 4; r++) begin
            if (|w_mask_kill[r*8 +: 8]) begin
                w_any_live = 1'b1;
                w_low_bot  = swarm_top_q + 10'(32 * r + 16);
            end
        end
    end
    assign w_landed = w_any_live && (w_low_bot >= land_line_p);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_MARCH;
            dir_q        <= 1'b1;
            swarm_left_q <= LEFT_RST;
            swarm_top_q  <= TOP_RST;
            mask_q       <= 32'hFFFF_FFFF;
            level_q      <= 3'd1;
            frame_cnt_q  <= '0;
            hit_q        <= 1'b0;
            add_life_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            swarm_left_q <= swarm_left_d;
            swarm_top_q  <= swarm_top_d;
            mask_q       <= mask_d;
            level_q      <= level_d;
            frame_cnt_q  <= frame_cnt_d;
            hit_q        <= hit_d;
            add_life_q   <= add_life_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        swarm_left_d = swarm_left_q;
        swarm_top_d  = swarm_top_q;
        mask_d       = w_mask_kill;
        level_d      = level_q;
        frame_cnt_d  = frame_cnt_q;
        hit_d        = |w_hit_vec;
        add_life_d   = 1'b0;
        case (state_q)
            ST_MARCH: begin
                if (frame_i && !freeze_i) begin
                    frame_cnt_d = w_tick ? 6'd0 : frame_cnt_q + 6'd1;
                end
                if (w_mask_kill == 32'd0) begin
                    state_d = ST_CLEARED;
                end else if (w_landed) begin
                    state_d = ST_LANDED;
                end else if (w_tick) begin
                    if (dir_q) begin
                        if (swarm_left_q + 10'd304 + step_x_p > 10'd629) begin
                            state_d = ST_DROP;
                        end else begin
                            swarm_left_d = swarm_left_q + step_x_p;
                        end
                    end else begin
                        if (swarm_left_q < 10'd9 + step_x_p) begin
                            state_d = ST_DROP;
                        end else begin
                            swarm_left_d = swarm_left_q - step_x_p;
                        end
                    end
                end
            end
            ST_DROP: begin
                swarm_top_d = swarm_top_q + drop_p;
                dir_d       = !dir_q;
                state_d     = (w_mask_kill == 32'd0) ? ST_CLEARED : ST_MARCH;
            end
            ST_CLEARED: begin
                if (resume_i) begin
                    level_d      = (level_q == 3'd7) ? 3'd7 : level_q + 3'd1;
                    add_life_d   = !level_d[0];
                    mask_d       = 32'hFFFF_FFFF;
                    swarm_left_d = LEFT_RST;
                    swarm_top_d  = TOP_RST;
                    dir_d        = 1'b1;
                    frame_cnt_d  = '0;
                    state_d      = ST_MARCH;
                end
            end
            default: begin
                if (resume_i) begin
                    level_d      = 3'd1;
                    mask_d       = 32'hFFFF_FFFF;
                    swarm_left_d = LEFT_RST;
                    swarm_top_d  = TOP_RST;
                    dir_d        = 1'b1;
                    frame_cnt_d  = '0;
                    state_d      = ST_MARCH;
                end
            end
        endcase
    end

    always_comb begin
        cleared_o = (state_q == ST_CLEARED);
        landed_o  = (state_q == ST_LANDED);
    end

    assign hit_enemy_o  = hit_q;
    assign add_life_o   = add_life_q;
    assign alive_mask_o = mask_q;
    assign swarm_left_o = swarm_left_q;
    assign swarm_top_o  = swarm_top_q;
    assign level_o      = level_q;

endmodule

`default_nettype wire

// File: tb/tb_alien_swarm.sv
// ============================================================================
//  Module   : tb_alien_swarm
//  Brief    : Scoreboard bench for alien_swarm: march, drop, hits, clear, land.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alien_swarm;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        frame_i = 1'b0;
    logic        freeze_i = 1'b0;
    logic        resume_i = 1'b0;
    logic        bullet_i = 1'b0;
    logic [9:0]  bullet_left_i = '0;
    logic [9:0]  bullet_right_i = '0;
    logic [9:0]  bullet_top_i = '0;
    logic [9:0]  bullet_bot_i = '0;
    logic        hit_enemy_o;
    logic [31:0] alive_mask_o;
    logic [9:0]  swarm_left_o;
    logic [9:0]  swarm_top_o;
    logic [2:0]  level_o;
    logic        add_life_o;
    logic        cleared_o;
    logic        landed_o;

    always #5 clk = ~clk;

    alien_swarm dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .frame_i        (frame_i),
        .freeze_i       (freeze_i),
        .resume_i       (resume_i),
        .bullet_i       (bullet_i),
        .bullet_left_i  (bullet_left_i),
        .bullet_right_i (bullet_right_i),
        .bullet_top_i   (bullet_top_i),
        .bullet_bot_i   (bullet_bot_i),
        .hit_enemy_o    (hit_enemy_o),
        .alive_mask_o   (alive_mask_o),
        .swarm_left_o   (swarm_left_o),
        .swarm_top_o    (swarm_top_o),
        .level_o        (level_o),
        .add_life_o     (add_life_o),
        .cleared_o      (cleared_o),
        .landed_o       (landed_o)
    );

    int total = 0;
    int bad = 0;
    int hit_cnt = 0;
    int add_cnt = 0;
    logic [31:0] exp_q[$];

    int mdl_left;
    int mdl_top;
    bit mdl_dir;
    bit mdl_landed;

    always @(negedge clk) begin
        if (hit_enemy_o) hit_cnt++;
        if (add_life_o) add_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sb_next();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic sb_expect(input logic [31:0] l, input logic [31:0] t, input logic [31:0] m,
                             input logic [31:0] lv, input logic [31:0] cl, input logic [31:0] ld);
        exp_q.push_back(l);
        exp_q.push_back(t);
        exp_q.push_back(m);
        exp_q.push_back(lv);
        exp_q.push_back(cl);
        exp_q.push_back(ld);
    endtask

    task automatic sb_compare(input string tag);
        check({tag, ".left"},    32'(swarm_left_o), sb_next());
        check({tag, ".top"},     32'(swarm_top_o),  sb_next());
        check({tag, ".mask"},    alive_mask_o,      sb_next());
        check({tag, ".level"},   32'(level_o),      sb_next());
        check({tag, ".cleared"}, 32'(cleared_o),    sb_next());
        check({tag, ".landed"},  32'(landed_o),     sb_next());
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        cyc(2);
        reset_i = 1'b0;
        mdl_left = 168;
        mdl_top = 48;
        mdl_dir = 1'b1;
        mdl_landed = 1'b0;
    endtask

    // Eight consecutive frame pulses, then two idle cycles for a possible drop to settle.
    task automatic step_once();
        frame_i = 1'b1;
        cyc(8);
        frame_i = 1'b0;
        cyc(2);
    endtask

    task automatic mdl_step();
        if (mdl_landed) return;
        if (mdl_dir) begin
            if (mdl_left + 304 + 4 > 629) begin
                mdl_top += 16;
                mdl_dir = 1'b0;
            end else begin
                mdl_left += 4;
            end
        end else begin
            if (mdl_left < 13) begin
                mdl_top += 16;
                mdl_dir = 1'b1;
            end else begin
                mdl_left -= 4;
            end
        end
        if (mdl_top + 112 >= 384) mdl_landed = 1'b1;
    endtask

    task automatic shoot(input int l, input int r, input int t, input int b, input int n);
        bullet_left_i  = 10'(l);
        bullet_right_i = 10'(r);
        bullet_top_i   = 10'(t);
        bullet_bot_i   = 10'(b);
        bullet_i = 1'b1;
        cyc(n);
        bullet_i = 1'b0;
        cyc(2);
    endtask

    task automatic resume_pulse();
        resume_i = 1'b1;
        cyc(1);
        resume_i = 1'b0;
        cyc(2);
    endtask

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int steps;

        // Reset values, sampled while reset is still applied.
        reset_i = 1'b1;
        cyc(2);
        sb_expect(168, 48, 32'hFFFF_FFFF, 1, 0, 0);
        sb_compare("reset");
        check("reset.hit", 32'(hit_enemy_o), 0);
        check("reset.add", 32'(add_life_o), 0);
        do_reset();

        // One march step, then nothing while frozen.
        step_once();
        sb_expect(172, 48, 32'hFFFF_FFFF, 1, 0, 0);
        sb_compare("step1");
        freeze_i = 1'b1;
        step_once();
        freeze_i = 1'b0;
        sb_expect(172, 48, 32'hFFFF_FFFF, 1, 0, 0);
        sb_compare("frozen");
        mdl_left = 172;

        // March to the right border, drop, then first step left.
        for (int i = 0; i < 38; i++) begin
            step_once();
            mdl_step();
        end
        sb_expect(324, 48, 32'hFFFF_FFFF, 1, 0, 0);
        sb_compare("at_324");
        step_once();
        sb_expect(324, 64, 32'hFFFF_FFFF, 1, 0, 0);
        sb_compare("dropped");
        step_once();
        sb_expect(320, 64, 32'hFFFF_FFFF, 1, 0, 0);
        sb_compare("left_step");

        // Lingering bullet over alien 0, hit test active while frozen.
        do_reset();
        freeze_i = 1'b1;
        base = hit_cnt;
        shoot(180, 186, 60, 70, 3);
        freeze_i = 1'b0;
        check("kill0.pulses", 32'(hit_cnt - base), 1);
        sb_expect(168, 48, 32'hFFFF_FFFE, 1, 0, 0);
        sb_compare("kill0");

        // Edges exactly touching aliens 0 and 1: no hit.
        base = hit_cnt;
        shoot(192, 208, 50, 60, 2);
        check("touch.pulses", 32'(hit_cnt - base), 0);
        sb_expect(168, 48, 32'hFFFF_FFFE, 1, 0, 0);
        sb_compare("touch");

        // Overlapping dead alien 0 and live alien 1: alien 1 dies.
        base = hit_cnt;
        shoot(191, 209, 50, 60, 1);
        check("kill1.pulses", 32'(hit_cnt - base), 1);
        sb_expect(168, 48, 32'hFFFF_FFFC, 1, 0, 0);
        sb_compare("kill1");

        // Two live aliens overlapped for two cycles: lowest index only, single pulse.
        do_reset();
        base = hit_cnt;
        shoot(191, 209, 50, 60, 2);
        check("prio.pulses", 32'(hit_cnt - base), 1);
        sb_expect(168, 48, 32'hFFFF_FFFE, 1, 0, 0);
        sb_compare("prio");

        // Clear the whole grid twice: level 2 grants a life, level 3 does not.
        do_reset();
        for (int lv = 2; lv <= 3; lv++) begin
            base = hit_cnt;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 8; c++) begin
                    shoot(172 + 40 * c, 188 + 40 * c, 52 + 32 * r, 60 + 32 * r, 1);
                end
            end
            check("clear.pulses", 32'(hit_cnt - base), 32);
            sb_expect(168, 48, 32'h0, lv - 1, 1, 0);
            sb_compare("cleared");
            base = add_cnt;
            resume_pulse();
            check("clear.add_life", 32'(add_cnt - base), (lv % 2 == 0) ? 1 : 0);
            sb_expect(168, 48, 32'hFFFF_FFFF, lv, 0, 0);
            sb_compare("next_level");
        end

        // March down until the bottom row reaches the landing line.
        mdl_left = 168;
        mdl_top = 48;
        mdl_dir = 1'b1;
        mdl_landed = 1'b0;
        steps = 0;
        while (!mdl_landed && steps < 1500) begin
            step_once();
            mdl_step();
            steps++;
            exp_q.push_back(32'(mdl_left));
            exp_q.push_back(32'(mdl_top));
            exp_q.push_back(32'(mdl_landed));
            check("march.left",   32'(swarm_left_o), sb_next());
            check("march.top",    32'(swarm_top_o),  sb_next());
            check("march.landed", 32'(landed_o),     sb_next());
        end
        sb_expect(mdl_left, 272, 32'hFFFF_FFFF, 3, 0, 1);
        sb_compare("landed");
        step_once();
        sb_expect(mdl_left, 272, 32'hFFFF_FFFF, 3, 0, 1);
        sb_compare("landed_hold");
        base = add_cnt;
        resume_pulse();
        check("land.add_life", 32'(add_cnt - base), 0);
        sb_expect(168, 48, 32'hFFFF_FFFF, 1, 0, 0);
        sb_compare("relaunch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alien_swarm.md
ALIEN_SWARM -- requirements
Module: alien_swarm
Interface
REQ-001 step_x_p, 10'd4, horizontal march step in pixels.
REQ-002 drop_p, 10'd16, vertical drop at each border reversal.
REQ-003 frames_per_step_p, 6'd8, frame_i pulses per march step.
REQ-004 land_line_p, 10'd384, y-coordinate at which the swarm has landed.
REQ-005 clk_i  in  1  clock; one clock only; reset is synchronous, active-high.
REQ-006 reset_i  in  1  synchronous active-high reset.
REQ-007 frame_i  in  1  one-cycle pulse per video frame.
REQ-008 freeze_i  in  1  player paused; march halts.
REQ-009 resume_i  in  1  shoot button; leaves CLEARED or LANDED.
REQ-010 bullet_i  in  1  player bullet in flight.
REQ-011 bullet_left_i/bullet_right_i/bullet_top_i/bullet_bot_i  in  10 each  player bullet box.
REQ-012 hit_enemy_o  out  1  one-cycle kill pulse; drives player hit_enemy_i.
REQ-013 alive_mask_o  out  32  live aliens; bit index r*8+c.
REQ-014 swarm_left_o/swarm_top_o  out  10 each  grid origin.
REQ-015 level_o  out  3  current level, 1..7.
REQ-016 add_life_o  out  1  one-cycle pulse; drives player add_life_i.
REQ-017 cleared_o / landed_o  out  1 each  level-state flags.
Function
REQ-018 Geometry: 4 rows x 8 columns; alien(r,c) left=swarm_left+40c, right=left+24, top=swarm_top+32r, bot=top+16; grid right edge = swarm_left+304.
REQ-019 FSM states: MARCH, DROP, CLEARED, LANDED; dir register selects right (1) or left (0).
REQ-020 Step tick: frame counter counts frame_i pulses in MARCH while freeze_i=0; tick when count reaches frames_per_step_p-1, then counter returns to 0.
REQ-021 MARCH tick, dir=1: if grid right edge + step_x_p > 629, go to DROP; else swarm_left += step_x_p.
REQ-022 MARCH tick, dir=0: if swarm_left < 9 + step_x_p, go to DROP; else swarm_left -= step_x_p.
REQ-023 DROP (one cycle): swarm_top += drop_p, dir inverts, return to MARCH.
REQ-024 Hit test: overlap is strict (bullet_left<right, bullet_right>left, bullet_top<bot, bullet_bot>top), evaluated only for live aliens while bullet_i=1 in MARCH or DROP.
REQ-025 On any overlap: clear the lowest-indexed overlapping alien only; assert registered hit_enemy_o for exactly one cycle.
REQ-026 Hit test is suppressed while hit_enemy_o=1, so a lingering bullet cannot cause a double kill.
REQ-027 The hit test runs irrespective of freeze_i.
REQ-028 Mask reaching zero, including on a kill cycle: go to CLEARED; cleared_o=1.
REQ-029 Landing: if the bottom of the lowest row with any live alien >= land_line_p, go to LANDED; landed_o=1. Landing has priority over a step in the same cycle.
REQ-030 CLEARED + resume_i: level_o increments, saturating at 7. add_life_o pulses when the new level is even. Mask reloads to all ones, origin returns to reset value, dir=1, state MARCH.
REQ-031 LANDED + resume_i: level_o=1, mask reload, origin reset, state MARCH; add_life_o stays low.
REQ-032 Adds are 10-bit unsigned; the border checks of REQ-021/022 prevent wrap.
Reset
REQ-033 reset_i: state MARCH, dir=1, swarm_left=168, swarm_top=48, mask=32'hFFFF_FFFF, level_o=1, frame counter 0.
REQ-034 All pulse outputs (hit_enemy_o, add_life_o) and flags (cleared_o, landed_o) are 0 in the cycle after reset.
REQ-035 Reset mid-step, mid-DROP or in CLEARED/LANDED overrides all other events.
Configuration
REQ-036 ALIEN_SPEEDUP_EN defined: when popcount(mask) <= 8, the step period is frames_per_step_p/2 frames, minimum 1.
REQ-037 ALIEN_SPEEDUP_EN undefined: the step period is always frames_per_step_p frames.
Verification
REQ-038 Reset, then 8 frame_i pulses -> swarm_left 168->172; then with freeze_i=1 -> no change.
REQ-039 March to swarm_left=324, next tick -> DROP, swarm_top=64, dir=0; next tick -> swarm_left=320.
REQ-040 Bullet box (180,186,60,70) held 3 cycles -> bit 0 cleared, single hit_enemy_o pulse, mask=32'hFFFF_FFFE.
REQ-041 Bullet overlapping aliens 0 and 1 edge-touching (left=192,right=208) -> only alien 1 killed (strict overlap); edges exactly touching -> no hit.
REQ-042 Kill all 32 -> cleared_o=1; resume_i -> level_o=2, add_life_o pulses once, mask all ones.
REQ-043 Force swarm_top so row-3 bottom = 384 -> landed_o=1; resume_i -> level_o=1, swarm_top=48.
